// File: rtl/icache_pkg.sv
// icache_pkg: FSM state encoding, default cache geometry and address-split helpers.
package icache_pkg;
  localparam int INDEX_BITS_DEF = 5;
  localparam int LINE_BYTES_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int ob);
    return a & ((32'd1 << ob) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int ob, input int ib);
    return (a >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ob, input int ib);
    return a >> (ob + ib);
  endfunction
  function automatic logic [31:0] line_base(input logic [31:0] a, input int ob);
    return a & ~((32'd1 << ob) - 32'd1);
  endfunction
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch request/response and byte-wide memory read signals of icache.
interface icache_if;
  logic        clear;
  logic        asking;
  logic [31:0] addr;
  logic [31:0] data;
  logic        data_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  modport slave (input clear, asking, addr, mem_gnt, mem_din, output data, data_ready, mem_req, mem_addr);
  modport master (output clear, asking, addr, mem_gnt, mem_din, input data, data_ready, mem_req, mem_addr);
endinterface

// File: rtl/icache_data_ram.sv
// icache_data_ram: byte-write line storage with a 4-byte asynchronous read port.
// Reads past the last line wrap to line 0, matching the index wrap of straddling fetches.
module icache_data_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);
  logic [7:0] r_mem [1<<AW];
  always_ff @(posedge clk) if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign o_rd_data[8*k +: 8] = r_mem[i_rd_addr + AW'(k)];
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache refilled byte by byte from memory.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt counters.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  icache_if.slave     bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = 32 - OFF_W - INDEX_BITS;
  localparam int RAM_AW = OFF_W + INDEX_BITS;
  state_t                  r_state;
  logic [31:0]             r_addr, r_data, r_mem_addr;
  logic                    r_ready, r_mem_req, r_wr_pend, r_fill_hi;
  logic [OFF_W-1:0]        r_wcnt;
  logic [(1<<INDEX_BITS)-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag [1<<INDEX_BITS];
  logic [31:0]             w_hi_addr, w_rd_data;
  logic [INDEX_BITS-1:0]   w_lo_idx, w_hi_idx, w_fill_idx;
  logic [TAG_W-1:0]        w_lo_tag, w_hi_tag;
  logic                    w_span, w_lo_hit, w_need_hi, w_fill_done;

  assign w_hi_addr   = r_addr + 32'd4;
  assign w_lo_idx    = INDEX_BITS'(addr_index(r_addr, OFF_W, INDEX_BITS));
  assign w_hi_idx    = INDEX_BITS'(addr_index(w_hi_addr, OFF_W, INDEX_BITS));
  assign w_lo_tag    = TAG_W'(addr_tag(r_addr, OFF_W, INDEX_BITS));
  assign w_hi_tag    = TAG_W'(addr_tag(w_hi_addr, OFF_W, INDEX_BITS));
  assign w_span      = addr_offset(r_addr, OFF_W) > 32'(LINE_BYTES - 4);
  assign w_lo_hit    = r_valid[w_lo_idx] && r_tag[w_lo_idx] == w_lo_tag;
  assign w_need_hi   = w_span && !(r_valid[w_hi_idx] && r_tag[w_hi_idx] == w_hi_tag);
  assign w_fill_idx  = r_fill_hi ? w_hi_idx : w_lo_idx;
  assign w_fill_done = r_state == FILL && r_wr_pend && &r_wcnt;

  icache_data_ram #(.AW(RAM_AW)) u_ram (
    .clk       (clk),
    .i_we      (r_wr_pend),
    .i_wr_addr ({w_fill_idx, r_wcnt}),
    .i_wr_data (bus.mem_din),
    .i_rd_addr (r_addr[RAM_AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign bus.data       = r_data;
  assign bus.data_ready = r_ready;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_wr_pend  <= 1'b0;
      r_fill_hi  <= 1'b0;
      r_wcnt     <= '0;
      r_valid    <= '0;
    end else begin
      r_ready   <= 1'b0;
      r_wr_pend <= r_mem_req && bus.mem_gnt && !bus.clear;
      if (bus.clear) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
        r_wcnt    <= '0;
      end else if (r_state == IDLE) begin
        if (bus.asking) begin
          r_addr  <= bus.addr & ~32'd1;
          r_state <= LOOKUP;
        end
      end else if (r_state == LOOKUP) begin
        if (!w_lo_hit || w_need_hi) begin
          r_state    <= FILL;
          r_fill_hi  <= w_lo_hit;
          r_valid[w_lo_hit ? w_hi_idx : w_lo_idx] <= 1'b0;
          r_mem_req  <= 1'b1;
          r_mem_addr <= line_base(w_lo_hit ? w_hi_addr : r_addr, OFF_W);
          r_wcnt     <= '0;
        end else begin
          r_data  <= w_rd_data;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      end else if (r_state == FILL) begin
        if (r_mem_req && bus.mem_gnt) begin
          r_mem_addr <= r_mem_addr + 32'd1;
          if (&r_mem_addr[OFF_W-1:0]) r_mem_req <= 1'b0;
        end
        if (r_wr_pend) r_wcnt <= r_wcnt + 1'b1;
        // a finished lower line chains straight into the upper fill, skipping a LOOKUP cycle
        if (w_fill_done) begin
          r_valid[w_fill_idx] <= 1'b1;
          r_tag[w_fill_idx]   <= r_fill_hi ? w_hi_tag : w_lo_tag;
          if (!r_fill_hi && w_need_hi) begin
            r_fill_hi          <= 1'b1;
            r_valid[w_hi_idx]  <= 1'b0;
            r_mem_req          <= 1'b1;
            r_mem_addr         <= line_base(w_hi_addr, OFF_W);
          end else begin
            r_state <= LOOKUP;
          end
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic        r_filled;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filled   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (!bus.clear) begin
      r_filled <= r_state == FILL || (r_state == LOOKUP && r_filled);
      if (r_state == LOOKUP && w_lo_hit && !w_need_hi && !r_filled) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_fill_done) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif
endmodule
